// File: rtl/sirius_fetch_pkg.sv
// Shared fetch-unit types: FSM state encoding, reset vector and slot record.
package sirius_fetch_pkg;

  typedef enum logic [1:0] {LOAD, REQ, WAIT, HOLD} fetch_state_e;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_slot_t;

  function automatic logic [31:0] align8(input logic [31:0] addr);
    return {addr[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/fetch_slot_sel.sv
// Splits a 64-bit cache line into the two decode slots based on which word the PC points at.
module fetch_slot_sel
  import sirius_fetch_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [31:0] fpc,
  output fetch_slot_t slot_1,
  output fetch_slot_t slot_2
);

  // An odd-word PC only has the upper word left in this line.
  always_comb begin
    slot_1.valid = 1'b1;
    slot_1.inst  = fpc[2] ? rdata[63:32] : rdata[31:0];
    slot_1.pc    = fpc;
    slot_2.valid = ~fpc[2];
    slot_2.inst  = rdata[63:32];
    slot_2.pc    = fpc + 32'd4;
  end

endmodule

// File: rtl/inst_fetch.sv
// Dual-issue instruction fetch: one aligned 64-bit cache request at a time, pair held for decode.
// Optional build macro FETCH_ADEL_CHECK_EN turns misaligned PCs into an address-error slot.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = sirius_fetch_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_address,
  input  logic        flush,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_ack,
  input  logic        ic_rvalid,
  input  logic [63:0] ic_rdata,
  input  logic        id_ready,
  output logic        id_valid_1,
  output logic        id_valid_2,
  output logic [31:0] id_inst_1,
  output logic [31:0] id_inst_2,
  output logic [31:0] id_pc_1,
  output logic [31:0] id_pc_2,
  output logic        id_adel,
  output logic        inst_ok_1,
  output logic        inst_ok_2
);
  import sirius_fetch_pkg::*;

  fetch_state_e state, state_n;
  logic         kill, kill_n;
  logic         req_n;
  logic [31:0]  addr_n;
  logic [31:0]  fpc, fpc_n;
  logic         adel_n;
  logic         addr_err;
  fetch_slot_t  slot_1, slot_2, slot_1_n, slot_2_n, sel_1, sel_2;

  fetch_slot_sel u_slot_sel (
    .rdata  (ic_rdata),
    .fpc    (fpc),
    .slot_1 (sel_1),
    .slot_2 (sel_2)
  );

`ifdef FETCH_ADEL_CHECK_EN
  assign addr_err = |pc_address[1:0];
`else
  assign addr_err = 1'b0;
`endif

  assign inst_ok_1  = (state == HOLD) && id_ready && !flush;
  assign inst_ok_2  = inst_ok_1 && slot_2.valid;
  assign id_valid_1 = slot_1.valid;
  assign id_valid_2 = slot_2.valid;
  assign id_inst_1  = slot_1.inst;
  assign id_inst_2  = slot_2.inst;
  assign id_pc_1    = slot_1.pc;
  assign id_pc_2    = slot_2.pc;

  always_comb begin
    state_n  = state;
    kill_n   = kill;
    req_n    = ic_req;
    addr_n   = ic_addr;
    fpc_n    = fpc;
    adel_n   = id_adel;
    slot_1_n = slot_1;
    slot_2_n = slot_2;
    case (state)
      LOAD: begin
        if (!flush) begin
          if (addr_err) begin
            slot_1_n = '{valid: 1'b1, inst: 32'h0, pc: pc_address};
            slot_2_n = '{valid: 1'b0, inst: 32'h0, pc: pc_address + 32'd4};
            adel_n   = 1'b1;
            state_n  = HOLD;
          end else begin
            fpc_n   = pc_address;
            addr_n  = align8(pc_address);
            req_n   = 1'b1;
            state_n = REQ;
          end
        end
      end
      REQ: begin
        if (flush) kill_n = 1'b1;
        if (ic_ack) begin
          req_n   = 1'b0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        // A killed response still has to be drained before the next request.
        if (ic_rvalid) begin
          if (kill || flush) begin
            kill_n  = 1'b0;
            state_n = LOAD;
          end else begin
            slot_1_n = sel_1;
            slot_2_n = sel_2;
            state_n  = HOLD;
          end
        end else if (flush) begin
          kill_n = 1'b1;
        end
      end
      HOLD: begin
        if (flush || id_ready) begin
          slot_1_n.valid = 1'b0;
          slot_2_n.valid = 1'b0;
          adel_n         = 1'b0;
          state_n        = LOAD;
        end
      end
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      kill    <= 1'b0;
      ic_req  <= 1'b0;
      ic_addr <= RESET_PC;
      id_adel <= 1'b0;
      slot_1  <= '{valid: 1'b0, inst: 32'h0, pc: RESET_PC};
      slot_2  <= '{valid: 1'b0, inst: 32'h0, pc: RESET_PC + 32'd4};
    end else begin
      state   <= state_n;
      kill    <= kill_n;
      ic_req  <= req_n;
      ic_addr <= addr_n;
      id_adel <= adel_n;
      slot_1  <= slot_1_n;
      slot_2  <= slot_2_n;
    end
  end

  always_ff @(posedge clk) begin
    fpc <= fpc_n;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(ic_ack && ic_rvalid));
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit sitting between the PC generator and decode in the dual-issue core. It takes the current PC, issues one 64-bit, 8-byte-aligned request at a time to the instruction cache, and presents up to two instructions to decode. On acceptance by decode it returns `inst_ok_1`/`inst_ok_2` to the PC generator. Flushes from branch or exception redirects drop any in-flight or held fetch.

## Interface
Parameters:
- `RESET_PC`, 32'hbfc0_0000 — value of `ic_addr`/`id_pc_1` fields before the first fetch; must match the PC reset vector.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset, synchronous, active-high.
- `pc_address` in 32 — current PC from the PC generator.
- `flush` in 1 — redirect this cycle (branch_taken | exception_taken).
- `ic_req` out 1 — cache request valid; registered.
- `ic_addr` out 32 — request address, `{pc[31:3],3'b000}`; registered.
- `ic_ack` in 1 — cache accepted request this cycle.
- `ic_rvalid` in 1 — response data valid; one pulse per accepted request.
- `ic_rdata` in 64 — `[31:0]` word at +0, `[63:32]` word at +4.
- `id_ready` in 1 — decode accepts the held pair this cycle.
- `id_valid_1`, `id_valid_2` out 1 — slot valid.
- `id_inst_1`, `id_inst_2` out 32 — instruction words.
- `id_pc_1`, `id_pc_2` out 32 — slot PCs; `id_pc_2 = id_pc_1 + 4`.
- `id_adel` out 1 — fetch address error on slot 1.
- `inst_ok_1`, `inst_ok_2` out 1 — slots consumed; combinational pulse to the PC generator.

## Operation
- States: LOAD, REQ, WAIT, HOLD. There is also a `kill` flag.
- LOAD:
  - Latch `fpc <= pc_address`.
  - Set `ic_addr <= align8(pc_address)` and `ic_req <= 1`.
  - Next state is REQ.
  - `ic_req` is 0 while in LOAD.
- REQ:
  - `ic_req` and `ic_addr` are held stable until `ic_ack`; a request is never withdrawn.
  - On `ic_ack`, `ic_req <= 0` and the next state is WAIT.
- WAIT: on `ic_rvalid`, the next state is HOLD.
  - If `fpc[2]==0`: slot1 gets `rdata[31:0]` and slot2 gets `rdata[63:32]`; both valid.
  - If `fpc[2]==1`: slot1 gets `rdata[63:32]` and slot2 is invalid.
- HOLD:
  - `id_valid_*` are asserted.
  - `inst_ok_1 = HOLD & id_ready & !flush`.
  - `inst_ok_2 = inst_ok_1 & id_valid_2`.
  - On `inst_ok_1`, the next state is LOAD; the PC advances on the same edge.
- Flush handling:
  - In LOAD: stay in LOAD.
  - In REQ or WAIT: set `kill`. The request completes normally. The `ic_rvalid` data is discarded, `kill` is cleared, and the next state is LOAD.
  - Flush in the same cycle as `ic_rvalid`: data is discarded and the next state is LOAD.
  - In HOLD: valids are dropped, no `inst_ok`, and the next state is LOAD.
  - Repeated flushes while `kill` is set have no further effect.
- Reset values:
  - State LOAD, `kill=0`, `ic_req=0`, `ic_addr=RESET_PC`.
  - All `id_valid`, `inst_ok` and `id_adel` are 0.
  - `id_inst` are 0; `id_pc_1=RESET_PC`.
  - Reset during any state abandons the outstanding request. The cache is reset on the same `rst`.

## Timing
- Minimum LOAD-to-HOLD time is 3 cycles with `ic_ack` in the first REQ cycle and `ic_rvalid` the cycle after.
- The earliest `inst_ok` is in the first HOLD cycle.
- Throughput with zero-wait cache: one pair per 4 cycles.
- `ic_rvalid` arriving in the same cycle as `ic_ack` is illegal; it is asserted against in simulation.
- `inst_ok_*` depend combinationally on `id_ready` and `flush`. All other outputs are registered.

## Configuration
- `FETCH_ADEL_CHECK_EN` defined:
  - In LOAD, if `pc_address[1:0]!=0`, no cache request is issued. The next state is HOLD with `id_valid_1=1`, `id_valid_2=0`, `id_adel=1`, `id_inst_1=0`, `id_pc_1=pc_address`.
  - Consumption follows the normal HOLD rule.
- Not defined: `pc_address[1:0]` is ignored and `id_adel` is tied 0.

## Structure
- Shared package `sirius_fetch_pkg` holds:
  - the `fetch_state_e` enum;
  - the `RESET_PC` constant;
  - the `fetch_slot_t` struct (valid, inst, pc).
- One sub-module, `fetch_slot_sel`: combinational selection of slot words from `ic_rdata` and `fpc[2]`.

## Test plan
- Aligned fetch: pc=0xbfc00000, ack same cycle as req, rdata=0x2222_2222_1111_1111 → slot1=0x11111111/0xbfc00000, slot2=0x22222222/0xbfc00004. With `id_ready=1`, `inst_ok_1`=`inst_ok_2`=1 for one cycle.
- Odd-word fetch: pc=0xbfc00004 → `ic_addr`=0xbfc00000, only slot1 (upper word) valid, `inst_ok_2` stays 0.
- Decode backpressure: `id_ready=0` for 5 HOLD cycles → outputs stable, no `inst_ok`, no new `ic_req`. Accepted on the 6th cycle.
- Flush in WAIT: flush one cycle after ack; response returns 3 cycles later → data never appears on `id_valid`. The next `ic_addr` is the redirected PC, e.g. 0xbfc00380.
- Flush in HOLD with `id_ready=1` in the same cycle → `inst_ok` stays 0, valids drop, LOAD follows.
- With `FETCH_ADEL_CHECK_EN` defined, pc=0xbfc00002 → no `ic_req`; HOLD with `id_adel=1`, `id_pc_1`=0xbfc00002.
